// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a time-division mux. Tracks frame alignment,
// assembles each frame in a shadow buffer, and publishes all channels in
// parallel once per complete frame.
module tdm_demux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_sof,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      frame_err,
    output logic                      locked,
    output logic [15:0]               frame_cnt
);

    localparam int unsigned      CW   = $clog2(CHANNELS);
    localparam logic [CW-1:0]    LAST = CW'(CHANNELS - 1);
    localparam logic [CW-1:0]    ONE  = CW'(1);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        COLLECT  = 2'd1,
        WAIT_SOF = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               idx_q, idx_d;
    logic [WIDTH-1:0]            shd_q [CHANNELS];
    logic [WIDTH-1:0]            shd_d [CHANNELS];
    logic [CHANNELS*WIDTH-1:0]   out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        frame_err_q, frame_err_d;
    logic                        locked_q, locked_d;
    logic [15:0]                 frame_cnt_q, frame_cnt_d;

    // State register; reset returns to HUNT so a fresh SOF is required.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: slot counter, shadow buffer and all outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                shd_q[k] <= '0;
            end
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            idx_q       <= idx_d;
            shd_q       <= shd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state and datapath decode; idle cycles hold everything but pulses.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shd_d       = shd_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        shd_d[0] = in_data;
                        idx_d    = ONE;
                        state_d  = COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_sof) begin
                        // Short frame: restart collection from this SOF word.
                        frame_err_d = 1'b1;
                        shd_d[0]    = in_data;
                        idx_d       = ONE;
                    end else begin
                        shd_d[idx_q] = in_data;
                        if (idx_q == LAST) begin
                            // Last word bypasses the shadow buffer straight to the output.
                            for (int unsigned k = 0; k < CHANNELS - 1; k++) begin
                                out_data_d[k*WIDTH +: WIDTH] = shd_q[k];
                            end
                            out_data_d[(CHANNELS-1)*WIDTH +: WIDTH] = in_data;
                            out_valid_d = 1'b1;
                            if (frame_cnt_q != 16'hFFFF) begin
                                frame_cnt_d = frame_cnt_q + 16'd1;
                            end
                            idx_d   = '0;
                            state_d = WAIT_SOF;
                        end else begin
                            idx_d = idx_q + ONE;
                        end
                    end
                end
                WAIT_SOF: begin
                    if (in_sof) begin
                        shd_d[0] = in_data;
                        idx_d    = ONE;
                        state_d  = COLLECT;
                    end else begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                        state_d     = HUNT;
                    end
                end
                default: begin
                    idx_d   = '0;
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == COLLECT) || (state_d == WAIT_SOF);
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign locked    = locked_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed scoreboard bench for tdm_demux (WIDTH=8, CHANNELS=4).
module tb_tdm_demux;

    localparam int unsigned W = 8;
    localparam int unsigned C = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_sof;
    logic [C*W-1:0]  out_data;
    logic            out_valid;
    logic            frame_err;
    logic            locked;
    logic [15:0]     frame_cnt;

    typedef struct {
        logic [31:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cnt  = '0;

    tdm_demux #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .locked    (locked),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record the frame this stimulus will complete.
    task automatic push_frame(input logic [31:0] data);
        exp_t e;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e.data = data;
        e.cnt  = exp_cnt;
        sb.push_back(e);
    endtask

    // Drive one cycle, then check the registered response 1 time unit after the edge.
    task automatic step(input logic v, input logic sof, input logic [W-1:0] d,
                        input logic exp_ov, input logic exp_err, input logic exp_lock);
        exp_t e;
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
        chk("locked",    {31'd0, locked},    {31'd0, exp_lock});
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data",  out_data, e.data);
                chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, e.cnt});
            end
        end
    endtask

    task automatic frame4(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
        step(1'b1, 1'b1, d0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, d1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, d2, 1'b0, 1'b0, 1'b1);
        push_frame({d3, d2, d1, d0});
        step(1'b1, 1'b0, d3, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sof   = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_locked",    {31'd0, locked}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        sb.delete();
        exp_cnt  = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;

        // Reset and idle
        do_reset(2);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("idle_out_data", out_data, 32'd0);
        chk("idle_frame_cnt", {16'd0, frame_cnt}, 32'd0);

        // Nominal frame
        frame4(8'h11, 8'h22, 8'h33, 8'h44);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("nom_hold", out_data, 32'h44332211);

        // Stalls then back-to-back frame
        do_reset(1);
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
        push_frame(32'h44332211);
        step(1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1);
        frame4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        chk("b2b_cnt", {16'd0, frame_cnt}, 32'd2);

        // Short frame
        do_reset(1);
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
        push_frame(32'h88776655);
        step(1'b1, 1'b0, 8'h88, 1'b1, 1'b0, 1'b1);

        // Long frame, hunt, reacquire
        step(1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        chk("hunt_hold", out_data, 32'h88776655);
        frame4(8'h10, 8'h20, 8'h30, 8'h40);

        // Reset mid-frame
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        do_reset(1);
        step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);

        // Saturation: preload the counter near its ceiling
        force dut.frame_cnt_q = 16'hFFFE;
        #1;
        release dut.frame_cnt_q;
        exp_cnt = 16'hFFFE;
        frame4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
        frame4(8'hB1, 8'hB2, 8'hB3, 8'hB4);
        frame4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("sat_cnt", {16'd0, frame_cnt}, 32'h0000FFFF);
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
